// File: rtl/q2_sequencer_if.sv
// Control and status bundle between the Q2 sequencer and the slice array/memory.
interface q2_sequencer_if #(
  parameter int unsigned WIDTH = 12
);
  logic [WIDTH-1:0] dbus_in;
  logic             a_zero;
  logic             run;
  logic             dep_req;
  logic             mem_rd;
  logic             mem_wr;
  logic             wra;
  logic             rda;
  logic             wrp;
  logic             rdp;
  logic             wrx;
  logic             rdx;
  logic             wrs;
  logic             xin_zero;
  logic             xin_shift;
  logic             xin_p;
  logic             xin_dbus;
  logic             incp;
  logic             dep;
  logic [1:0]       alu_op;
  logic             halted;

  modport master (
    input  dbus_in, a_zero, run, dep_req,
    output mem_rd, mem_wr, wra, rda, wrp, rdp, wrx, rdx, wrs,
           xin_zero, xin_shift, xin_p, xin_dbus, incp, dep, alu_op, halted
  );

  modport slave (
    output dbus_in, a_zero, run, dep_req,
    input  mem_rd, mem_wr, wra, rda, wrp, rdp, wrx, rdx, wrs,
           xin_zero, xin_shift, xin_p, xin_dbus, incp, dep, alu_op, halted
  );
endinterface

// File: rtl/q2_sequencer.sv
// Q2 control sequencer: fetch/operand/execute/deposit state machine driving slice strobes.
// Outputs are decoded from the next state and registered, so they change only on clock edges.
module q2_sequencer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             incp_clk,
  input  logic             rst,
  q2_sequencer_if.master   bus
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [3:0] {
    S_HALT, S_F0, S_F1, S_F2, S_O0, S_O1, S_O2,
    S_E0, S_E1, S_E2, S_D0, S_D1, S_D2
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_LDA = 3'd0, OP_STA = 3'd1, OP_ADD = 3'd2, OP_NOR = 3'd3,
    OP_JMP = 3'd4, OP_JZ  = 3'd5, OP_SHR = 3'd6, OP_HLT = 3'd7
  } op_e;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       wra;
    logic       rda;
    logic       wrp;
    logic       rdp;
    logic       wrx;
    logic       rdx;
    logic       wrs;
    logic       xin_zero;
    logic       xin_shift;
    logic       xin_p;
    logic       xin_dbus;
    logic       incp;
    logic       dep;
    logic [1:0] alu_op;
    logic       halted;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{halted: 1'b1, default: '0};

  state_e           state_q, state_d;
  ctl_t             ctl_q, ctl_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  op_e              op;
  logic [1:0]       alu_sel;
  logic             unused_ir_c;

  assign op          = op_e'(ir_q[WIDTH-1 -: OP_W]);
  assign unused_ir_c = ^ir_q[WIDTH-OP_W-1:0];

  always_comb begin
    case (op)
      OP_LDA:  alu_sel = 2'b00;
      OP_ADD:  alu_sel = 2'b01;
      OP_NOR:  alu_sel = 2'b10;
      default: alu_sel = 2'b11;
    endcase
  end

  // State, instruction and decoded-output registers
  always_ff @(posedge incp_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HALT;
      ctl_q   <= CTL_RESET;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      ir_q    <= ir_d;
    end
  end

  // Next state, then the outputs belonging to that next state
  always_comb begin
    state_d = state_q;
    ctl_d   = '0;
    ir_d    = ir_q;

    case (state_q)
      S_HALT: begin
        if (bus.run)          state_d = S_F0;
        else if (bus.dep_req) state_d = S_D0;
      end
      S_F0: state_d = S_F1;
      S_F1: begin
        state_d = S_F2;
        ir_d    = bus.dbus_in;
      end
      S_F2: begin
        case (op)
          OP_HLT:  state_d = S_HALT;
          OP_SHR:  state_d = S_E0;
          default: state_d = S_O0;
        endcase
      end
      S_O0: state_d = S_O1;
      S_O1: state_d = S_O2;
      S_O2: state_d = S_E0;
      S_E0: state_d = (op == OP_JMP || op == OP_JZ) ? S_F0 : S_E1;
      S_E1: state_d = (op == OP_STA) ? S_E2 : S_F0;
      S_E2: state_d = S_F0;
      S_D0: state_d = S_D1;
      S_D1: state_d = S_D2;
      S_D2: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    case (state_d)
      S_HALT: ctl_d.halted = 1'b1;
      S_F0, S_F1, S_O0: begin
        ctl_d.rdp    = 1'b1;
        ctl_d.mem_rd = 1'b1;
      end
      S_O1: begin
        ctl_d.rdp      = 1'b1;
        ctl_d.mem_rd   = 1'b1;
        ctl_d.wrx      = 1'b1;
        ctl_d.xin_dbus = 1'b1;
      end
      S_F2, S_O2, S_D2: ctl_d.incp = 1'b1;
      S_E0: begin
        case (op)
          OP_STA: begin
            ctl_d.rdx = 1'b1;
            ctl_d.rda = 1'b1;
          end
          OP_JMP: ctl_d.wrp = 1'b1;
          // a_zero is sampled on the O2->E0 edge, the only way into E0 for JZ
          OP_JZ:  ctl_d.wrp = bus.a_zero;
          OP_SHR: ctl_d.alu_op = 2'b11;
          default: begin
            ctl_d.rdx    = 1'b1;
            ctl_d.mem_rd = 1'b1;
            ctl_d.alu_op = alu_sel;
          end
        endcase
      end
      S_E1: begin
        case (op)
          OP_STA: begin
            ctl_d.rdx    = 1'b1;
            ctl_d.rda    = 1'b1;
            ctl_d.mem_wr = 1'b1;
          end
          OP_SHR: begin
            ctl_d.alu_op = 2'b11;
            ctl_d.wra    = 1'b1;
            ctl_d.wrs    = 1'b1;
          end
          default: begin
            ctl_d.rdx    = 1'b1;
            ctl_d.mem_rd = 1'b1;
            ctl_d.alu_op = alu_sel;
            ctl_d.wra    = 1'b1;
            ctl_d.wrs    = (op == OP_ADD);
          end
        endcase
      end
      S_E2: begin
        ctl_d.rdx = 1'b1;
        ctl_d.rda = 1'b1;
      end
      S_D0: begin
        ctl_d.rdp = 1'b1;
        ctl_d.dep = 1'b1;
      end
      S_D1: begin
        ctl_d.rdp    = 1'b1;
        ctl_d.dep    = 1'b1;
        ctl_d.mem_wr = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  assign bus.mem_rd    = ctl_q.mem_rd;
  assign bus.mem_wr    = ctl_q.mem_wr;
  assign bus.wra       = ctl_q.wra;
  assign bus.rda       = ctl_q.rda;
  assign bus.wrp       = ctl_q.wrp;
  assign bus.rdp       = ctl_q.rdp;
  assign bus.wrx       = ctl_q.wrx;
  assign bus.rdx       = ctl_q.rdx;
  assign bus.wrs       = ctl_q.wrs;
  assign bus.xin_zero  = ctl_q.xin_zero;
  assign bus.xin_shift = ctl_q.xin_shift;
  assign bus.xin_p     = ctl_q.xin_p;
  assign bus.xin_dbus  = ctl_q.xin_dbus;
  assign bus.incp      = ctl_q.incp;
  assign bus.dep       = ctl_q.dep;
  assign bus.alu_op    = ctl_q.alu_op;
  assign bus.halted    = ctl_q.halted;

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed bench for q2_sequencer: per-cycle output vectors against hand-built expectations,
// plus per-cycle invariant checks on the strobe set.
module tb_q2_sequencer;

  localparam int unsigned WIDTH = 12;

  localparam logic [17:0] MRD  = 18'h00001;
  localparam logic [17:0] MWR  = 18'h00002;
  localparam logic [17:0] WRA  = 18'h00004;
  localparam logic [17:0] RDA  = 18'h00008;
  localparam logic [17:0] WRP  = 18'h00010;
  localparam logic [17:0] RDP  = 18'h00020;
  localparam logic [17:0] WRX  = 18'h00040;
  localparam logic [17:0] RDX  = 18'h00080;
  localparam logic [17:0] WRS  = 18'h00100;
  localparam logic [17:0] XD   = 18'h01000;
  localparam logic [17:0] INC  = 18'h02000;
  localparam logic [17:0] DEP  = 18'h04000;
  localparam logic [17:0] A01  = 18'h08000;
  localparam logic [17:0] A10  = 18'h10000;
  localparam logic [17:0] A11  = 18'h18000;
  localparam logic [17:0] HLT  = 18'h20000;
  localparam logic [17:0] RM   = RDP | MRD;
  localparam logic [17:0] OPX  = RDP | MRD | WRX | XD;

  logic incp_clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [17:0] vec;
  logic [17:0] prev;
  logic [17:0] exq[$];

  q2_sequencer_if #(.WIDTH(WIDTH)) bus ();

  q2_sequencer #(.WIDTH(WIDTH)) dut (
    .incp_clk (incp_clk),
    .rst      (rst),
    .bus      (bus)
  );

  assign vec = {bus.halted, bus.alu_op, bus.dep, bus.incp, bus.xin_dbus, bus.xin_p,
                bus.xin_shift, bus.xin_zero, bus.wrs, bus.rdx, bus.wrx, bus.rdp,
                bus.wrp, bus.rda, bus.wra, bus.mem_wr, bus.mem_rd};

  initial incp_clk = 1'b0;
  always #5 incp_clk = ~incp_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Invariants on every sampled cycle out of reset
  always @(negedge incp_clk) begin
    if (!rst) begin
      check("inv_rdp_rdx", 32'(bus.rdp & bus.rdx), 32'd0);
      check("inv_drivers", 32'($countones({bus.rda, bus.mem_rd, bus.dep}) <= 1), 32'd1);
      check("inv_xin", 32'($countones({bus.xin_zero, bus.xin_shift, bus.xin_p, bus.xin_dbus}) <= 1), 32'd1);
      if (bus.mem_wr)
        check("inv_mem_wr_drv", 32'($countones({bus.rda, bus.dep})), 32'd1);
      check("inv_strobe_1cyc", 32'(vec & prev & (WRA | WRP | WRX | WRS | MWR)), 32'd0);
    end
    prev <= vec;
  end

  // Start one instruction from HALT and compare each cycle with exq; caller sits at a negedge
  task automatic exec(input string tag, input logic [WIDTH-1:0] word, input logic az);
    bus.dbus_in = word;
    bus.a_zero  = az;
    bus.run     = 1'b1;
    @(posedge incp_clk);
    #1 bus.run = 1'b0;
    for (int i = 0; i < exq.size(); i++) begin
      @(negedge incp_clk);
      check($sformatf("%s c%0d", tag, i + 1), 32'(vec), 32'(exq[i]));
      if (i == 2) bus.dbus_in = 12'hE00;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    prev        = '0;
    rst         = 1'b1;
    bus.dbus_in = '0;
    bus.a_zero  = 1'b0;
    bus.run     = 1'b0;
    bus.dep_req = 1'b0;
    repeat (2) @(negedge incp_clk);
    check("reset_vec", 32'(vec), 32'(HLT));
    rst = 1'b0;
    @(negedge incp_clk);
    check("halt_idle", 32'(vec), 32'(HLT));

    exq = {RM, RM, INC, RM, OPX, INC, RDX|MRD, RDX|MRD|WRA, RM, RM, INC, HLT};
    exec("lda", 12'h000, 1'b0);
    exq = {RM, RM, INC, RM, OPX, INC, RDX|MRD|A01, RDX|MRD|A01|WRA|WRS, RM, RM, INC, HLT};
    exec("add", 12'h400, 1'b0);
    exq = {RM, RM, INC, RM, OPX, INC, RDX|MRD|A10, RDX|MRD|A10|WRA, RM, RM, INC, HLT};
    exec("nor", 12'h600, 1'b0);
    exq = {RM, RM, INC, RM, OPX, INC, RDX|RDA, RDX|RDA|MWR, RDX|RDA, RM, RM, INC, HLT};
    exec("sta", 12'h200, 1'b0);
    exq = {RM, RM, INC, RM, OPX, INC, WRP, RM, RM, INC, HLT};
    exec("jmp", 12'h800, 1'b0);
    exq = {RM, RM, INC, RM, OPX, INC, WRP, RM, RM, INC, HLT};
    exec("jz1", 12'hA00, 1'b1);
    exq = {RM, RM, INC, RM, OPX, INC, 18'h0, RM, RM, INC, HLT};
    exec("jz0", 12'hA00, 1'b0);
    exq = {RM, RM, INC, A11, A11|WRA|WRS, RM, RM, INC, HLT};
    exec("shr", 12'hC00, 1'b0);
    exq = {RM, RM, INC, HLT, HLT};
    exec("hlt", 12'hE00, 1'b0);

    // run has priority over dep_req
    bus.dep_req = 1'b1;
    exq = {RM, RM, INC, HLT};
    exec("run_pri", 12'hE00, 1'b0);
    bus.dep_req = 1'b0;
    @(negedge incp_clk);

    // Level-held dep_req: two back-to-back deposits
    bus.dep_req = 1'b1;
    exq = {RDP|DEP, RDP|DEP|MWR, INC, HLT, RDP|DEP, RDP|DEP|MWR, INC, HLT};
    for (int i = 0; i < 8; i++) begin
      @(negedge incp_clk);
      check($sformatf("dep c%0d", i + 1), 32'(vec), 32'(exq[i]));
    end
    bus.dep_req = 1'b0;
    @(negedge incp_clk);
    check("dep_done", 32'(vec), 32'(HLT));

    // Asynchronous reset in E1 of ADD
    bus.dbus_in = 12'h400;
    bus.run     = 1'b1;
    @(posedge incp_clk);
    #1 bus.run = 1'b0;
    repeat (8) @(negedge incp_clk);
    check("rst_pre_wra", 32'(bus.wra), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_async", 32'(vec), 32'(HLT));
    @(negedge incp_clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge incp_clk);
      check($sformatf("rst_after c%0d", i + 1), 32'(vec), 32'(HLT));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
